// File: rtl/cpu_pkg.sv
// Types and helpers shared by the execute/memory pipeline boundary.
// The bundle struct documents the default-width payload layout.
package cpu_pkg;

  localparam int CPU_DATA_W   = 32;
  localparam int CPU_REG_ID_W = 3;

  typedef enum logic [1:0] {
    BYTE  = 2'b00,
    WORD  = 2'b01,
    DWORD = 2'b10
  } mem_size_t;

  localparam logic [1:0] MEM_SIZE_ILLEGAL = 2'b11;

  typedef struct packed {
    logic [CPU_DATA_W-1:0]   alu_res1;
    logic [CPU_DATA_W-1:0]   alu_res2;
    logic                    mem_rd_en;
    logic                    mem_wr_en;
    logic [1:0]              mem_rd_size;
    logic [1:0]              mem_wr_size;
    logic [CPU_REG_ID_W-1:0] wb_reg_id;
    logic                    ld_reg;
    logic                    ld_esp;
  } ex_mem_bundle_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b01,
    SKID_FULL  = 2'b10
  } skid_state_t;

  // A size only matters when its access is actually enabled.
  function automatic logic illegal_access(input logic en, input logic [1:0] size);
    return en && (size == MEM_SIZE_ILLEGAL);
  endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic two-entry skid register with valid/ready handshake and flush.
// in_ready is registered, so there is no combinational path from out_ready.
module pipe_skid_reg
  import cpu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         out_valid_q, out_valid_d;
  logic         in_ready_q, in_ready_d;
  logic         push, pop;

  assign push = in_valid & in_ready_q;
  assign pop  = out_valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = SKID_EMPTY;
    end else begin
      case (state_q)
        SKID_EMPTY: begin
          if (push) begin
            main_d  = in_data;
            state_d = SKID_ONE;
          end
        end
        SKID_ONE: begin
          // Simultaneous in/out replaces the head; the skid stays unused.
          if (push && pop) begin
            main_d = in_data;
          end else if (push) begin
            skid_d  = in_data;
            state_d = SKID_FULL;
          end else if (pop) begin
            state_d = SKID_EMPTY;
          end
        end
        SKID_FULL: begin
          if (pop) begin
            main_d  = skid_q;
            state_d = SKID_ONE;
          end
        end
        default: state_d = SKID_EMPTY;
      endcase
    end
    out_valid_d = (state_d != SKID_EMPTY);
    in_ready_d  = (state_d != SKID_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SKID_EMPTY;
      main_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // The skid is never observed while invalid, so it carries no reset.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: rtl/ex_mem_skid.sv
// Execute-to-memory pipeline boundary: skid-buffered bundle transfer plus
// a saturating stall counter and a sticky illegal-access-size flag.
module ex_mem_skid
  import cpu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_ID_W    = 3,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_alu_res1,
  input  logic [DATA_W-1:0]      in_alu_res2,
  input  logic                   in_mem_rd_en,
  input  logic                   in_mem_wr_en,
  input  logic [1:0]             in_mem_rd_size,
  input  logic [1:0]             in_mem_wr_size,
  input  logic [REG_ID_W-1:0]    in_wb_reg_id,
  input  logic                   in_ld_reg,
  input  logic                   in_ld_esp,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_W-1:0]      out_alu_res1,
  output logic [DATA_W-1:0]      out_alu_res2,
  output logic                   out_mem_rd_en,
  output logic                   out_mem_wr_en,
  output logic [1:0]             out_mem_rd_size,
  output logic [1:0]             out_mem_wr_size,
  output logic [REG_ID_W-1:0]    out_wb_reg_id,
  output logic                   out_ld_reg,
  output logic                   out_ld_esp,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic                   size_err
);

  localparam int BUNDLE_W = 2 * DATA_W + 2 + 2 + 2 + REG_ID_W + 2;

  logic [BUNDLE_W-1:0]    in_bus, out_bus;
  logic                   push;
  logic                   illegal_in;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   size_err_q, size_err_d;

  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Field order is local to this boundary; payload passes through bit-exact.
  assign in_bus = {in_alu_res1, in_alu_res2, in_mem_rd_en, in_mem_wr_en,
                   in_mem_rd_size, in_mem_wr_size, in_wb_reg_id,
                   in_ld_reg, in_ld_esp};

  assign {out_alu_res1, out_alu_res2, out_mem_rd_en, out_mem_wr_en,
          out_mem_rd_size, out_mem_wr_size, out_wb_reg_id,
          out_ld_reg, out_ld_esp} = out_bus;

  pipe_skid_reg #(
    .W (BUNDLE_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_bus),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_bus)
  );

  assign push       = in_valid & in_ready & ~flush;
  assign illegal_in = illegal_access(in_mem_rd_en, in_mem_rd_size) |
                      illegal_access(in_mem_wr_en, in_mem_wr_size);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    size_err_d  = size_err_q;
    if (out_valid && !out_ready && !flush) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
    if (push && illegal_in) begin
      size_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      size_err_q  <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      size_err_q  <= size_err_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign size_err  = size_err_q;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Bench for ex_mem_skid: directed and random steps checked against a FIFO
// reference model, plus a narrow-counter instance for saturation.
module tb_ex_mem_skid;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        rd_en;
    logic        wr_en;
    logic [1:0]  rd_sz;
    logic [1:0]  wr_sz;
    logic [2:0]  reg_id;
    logic        ld_reg;
    logic        ld_esp;
  } bnd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic  rst_n, flush, in_valid, out_ready;
  bnd_t  drv;
  logic  in_ready, out_valid, size_err;
  logic [31:0] out_alu_res1, out_alu_res2;
  logic        out_mem_rd_en, out_mem_wr_en, out_ld_reg, out_ld_esp;
  logic [1:0]  out_mem_rd_size, out_mem_wr_size;
  logic [2:0]  out_wb_reg_id;
  logic [15:0] stall_cnt;
  bnd_t        obs;

  logic        s_valid, s_ready, s_flush;
  logic        s_in_ready, s_out_valid, s_size_err;
  logic [31:0] s_alu_res1, s_alu_res2;
  logic        s_rd_en, s_wr_en, s_ld_reg, s_ld_esp;
  logic [1:0]  s_rd_sz, s_wr_sz;
  logic [2:0]  s_reg_id;
  logic [3:0]  s_stall_cnt;

  ex_mem_skid dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_res1(drv.r1), .in_alu_res2(drv.r2),
    .in_mem_rd_en(drv.rd_en), .in_mem_wr_en(drv.wr_en),
    .in_mem_rd_size(drv.rd_sz), .in_mem_wr_size(drv.wr_sz),
    .in_wb_reg_id(drv.reg_id), .in_ld_reg(drv.ld_reg), .in_ld_esp(drv.ld_esp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_res1(out_alu_res1), .out_alu_res2(out_alu_res2),
    .out_mem_rd_en(out_mem_rd_en), .out_mem_wr_en(out_mem_wr_en),
    .out_mem_rd_size(out_mem_rd_size), .out_mem_wr_size(out_mem_wr_size),
    .out_wb_reg_id(out_wb_reg_id), .out_ld_reg(out_ld_reg), .out_ld_esp(out_ld_esp),
    .stall_cnt(stall_cnt), .size_err(size_err)
  );

  ex_mem_skid #(.STALL_CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .flush(s_flush),
    .in_valid(s_valid), .in_ready(s_in_ready),
    .in_alu_res1(drv.r1), .in_alu_res2(drv.r2),
    .in_mem_rd_en(drv.rd_en), .in_mem_wr_en(drv.wr_en),
    .in_mem_rd_size(drv.rd_sz), .in_mem_wr_size(drv.wr_sz),
    .in_wb_reg_id(drv.reg_id), .in_ld_reg(drv.ld_reg), .in_ld_esp(drv.ld_esp),
    .out_valid(s_out_valid), .out_ready(s_ready),
    .out_alu_res1(s_alu_res1), .out_alu_res2(s_alu_res2),
    .out_mem_rd_en(s_rd_en), .out_mem_wr_en(s_wr_en),
    .out_mem_rd_size(s_rd_sz), .out_mem_wr_size(s_wr_sz),
    .out_wb_reg_id(s_reg_id), .out_ld_reg(s_ld_reg), .out_ld_esp(s_ld_esp),
    .stall_cnt(s_stall_cnt), .size_err(s_size_err)
  );

  assign obs = {out_alu_res1, out_alu_res2, out_mem_rd_en, out_mem_wr_en,
                out_mem_rd_size, out_mem_wr_size, out_wb_reg_id,
                out_ld_reg, out_ld_esp};

  // Reference model: a bounded FIFO of up to two bundles.
  bnd_t        mq[$];
  logic        m_rdy;
  logic [15:0] m_cnt;
  logic        m_err;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [79:0] o, input logic [79:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic is_illegal(input bnd_t b);
    return (b.rd_en && b.rd_sz == 2'b11) || (b.wr_en && b.wr_sz == 2'b11);
  endfunction

  function automatic bnd_t mk(input logic [31:0] r1, input logic [31:0] r2);
    bnd_t b;
    b.r1 = r1; b.r2 = r2;
    b.rd_en = r1[0]; b.wr_en = r1[1];
    b.rd_sz = 2'b10; b.wr_sz = 2'b01;
    b.reg_id = r2[4:2]; b.ld_reg = 1'b1; b.ld_esp = r2[3];
    return b;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_rdy = 1'b0;
    m_cnt = '0;
    m_err = 1'b0;
  endtask

  task automatic model_edge();
    logic pop, push;
    if (flush) begin
      mq.delete();
    end else begin
      pop  = (mq.size() > 0) && out_ready;
      push = in_valid && m_rdy;
      if (mq.size() > 0 && !out_ready && m_cnt != 16'hFFFF) m_cnt++;
      if (push && is_illegal(drv)) m_err = 1'b1;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(drv);
    end
    m_rdy = (mq.size() < 2);
  endtask

  task automatic expect_all();
    check("out_valid", 80'(out_valid), 80'(mq.size() > 0));
    check("in_ready", 80'(in_ready), 80'(m_rdy));
    check("stall_cnt", 80'(stall_cnt), 80'(m_cnt));
    check("size_err", 80'(size_err), 80'(m_err));
    if (mq.size() > 0) check("payload", 80'(obs), 80'(mq[0]));
  endtask

  task automatic step(input logic v, input bnd_t b, input logic ordy, input logic fl);
    in_valid = v; drv = b; out_ready = ordy; flush = fl;
    @(posedge clk);
    model_edge();
    #1;
    expect_all();
  endtask

  initial begin
    bnd_t b, idle;
    idle = '0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; drv = '0;
    s_valid = 1'b0; s_ready = 1'b1; s_flush = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 80'(out_valid), 80'(0));
    check("rst_in_ready", 80'(in_ready), 80'(0));
    check("rst_stall_cnt", 80'(stall_cnt), 80'(0));
    check("rst_size_err", 80'(size_err), 80'(0));
    check("rst_payload", 80'(obs), 80'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, idle, 1'b1, 1'b0);
    check("in_ready_after_rst", 80'(in_ready), 80'(1));

    // Streaming with out_ready held high
    for (int i = 0; i < 4; i++) begin
      step(1'b1, mk(32'h1000 + i, 32'h100 + 4 * i), 1'b1, 1'b0);
      check("stream_res2", 80'(out_alu_res2), 80'(32'h100 + 4 * i));
      check("stream_in_ready", 80'(in_ready), 80'(1));
    end
    step(1'b0, idle, 1'b1, 1'b0);

    // Stall fill: A and B accepted, C held off until the drain frees space
    step(1'b1, mk(32'hAAAA0000, 32'h200), 1'b0, 1'b0);
    step(1'b1, mk(32'hBBBB0000, 32'h204), 1'b0, 1'b0);
    check("fill_in_ready", 80'(in_ready), 80'(0));
    step(1'b1, mk(32'hCCCC0000, 32'h208), 1'b0, 1'b0);
    step(1'b1, mk(32'hCCCC0000, 32'h208), 1'b0, 1'b0);
    check("fill_head_A", 80'(out_alu_res1), 80'(32'hAAAA0000));
    step(1'b1, mk(32'hCCCC0000, 32'h208), 1'b1, 1'b0);
    check("drain_head_B", 80'(out_alu_res1), 80'(32'hBBBB0000));
    step(1'b1, mk(32'hCCCC0000, 32'h208), 1'b1, 1'b0);
    check("drain_head_C", 80'(out_alu_res1), 80'(32'hCCCC0000));
    step(1'b0, idle, 1'b1, 1'b0);
    check("fill_stall_cnt", 80'(stall_cnt), 80'(3));

    // Flush while FULL with a bundle offered
    step(1'b1, mk(32'hEEEE0000, 32'h300), 1'b0, 1'b0);
    step(1'b1, mk(32'hFFFF0000, 32'h304), 1'b0, 1'b0);
    step(1'b1, mk(32'h99990000, 32'h308), 1'b0, 1'b1);
    check("flush_out_valid", 80'(out_valid), 80'(0));
    check("flush_in_ready", 80'(in_ready), 80'(1));
    step(1'b1, mk(32'hDDDD0000, 32'h30C), 1'b1, 1'b0);
    check("flush_head_D", 80'(out_alu_res1), 80'(32'hDDDD0000));
    step(1'b0, idle, 1'b1, 1'b0);
    check("flush_D_alone", 80'(out_valid), 80'(0));

    // Illegal sizes: disabled access ignored, enabled access sets sticky flag
    b = mk(32'h12340000, 32'h400);
    b.rd_en = 1'b0; b.rd_sz = 2'b11;
    step(1'b1, b, 1'b1, 1'b0);
    check("size_disabled", 80'(size_err), 80'(0));
    b = mk(32'h56780000, 32'h404);
    b.wr_en = 1'b1; b.wr_sz = 2'b11;
    step(1'b1, b, 1'b1, 1'b0);
    check("size_enabled", 80'(size_err), 80'(1));
    check("size_delivered", 80'(obs), 80'(b));
    step(1'b0, idle, 1'b1, 1'b0);
    step(1'b0, idle, 1'b1, 1'b1);
    check("size_sticky", 80'(size_err), 80'(1));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      b.r1 = $urandom; b.r2 = $urandom;
      b.rd_en = 1'($urandom_range(0, 1)); b.wr_en = 1'($urandom_range(0, 1));
      b.rd_sz = 2'($urandom_range(0, 3)); b.wr_sz = 2'($urandom_range(0, 3));
      b.reg_id = 3'($urandom_range(0, 7));
      b.ld_reg = 1'($urandom_range(0, 1)); b.ld_esp = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), b, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 15) == 0));
    end

    // Asynchronous reset between edges while FULL
    step(1'b0, idle, 1'b1, 1'b1);
    step(1'b1, mk(32'h11110000, 32'h500), 1'b0, 1'b0);
    step(1'b1, mk(32'h22220000, 32'h504), 1'b0, 1'b0);
    check("pre_rst_full", 80'(in_ready), 80'(0));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_out_valid", 80'(out_valid), 80'(0));
    check("arst_stall_cnt", 80'(stall_cnt), 80'(0));
    check("arst_size_err", 80'(size_err), 80'(0));
    #2;
    rst_n = 1'b1;
    step(1'b0, idle, 1'b1, 1'b0);
    check("arst_in_ready", 80'(in_ready), 80'(1));

    // Saturation on the 4-bit counter instance
    in_valid = 1'b0;
    drv = mk(32'h77770000, 32'h600);
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_ready = 1'b0;
    check("sat_accept", 80'(s_out_valid), 80'(1));
    check("sat_start", 80'(s_stall_cnt), 80'(0));
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (k == 10 || k == 15 || k == 16 || k == 20)
        check("sat_stall_cnt", 80'(s_stall_cnt), 80'((k > 15) ? 15 : k));
    end
    check("sat_payload", 80'(s_alu_res1), 80'(32'h77770000));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_mem_skid.md
Name: ex_mem_skid

Overview:
- Pipeline boundary between the execute stage (alu1/alu2 results) and the memory stage.
- Captures one execute bundle per accepted transfer: alu_res1, alu_res2, memory control and writeback control.
- Presents the bundle downstream with a valid/ready handshake.
- Holds a two-entry skid so that a memory-stage stall never drops an in-flight execute result.
- Also provides flush (branch/exception redirect), a saturating stall counter and a sticky illegal-size flag.

Parameters:
- DATA_W, 32, width of alu_res1/alu_res2 payload fields.
- REG_ID_W, 3, width of writeback register id.
- STALL_CNT_W, 16, width of saturating stall-cycle counter.

Ports:
- clk  input  1  pipeline clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all held bundles.
- in_valid  input  1  execute bundle valid.
- in_ready  output  1  block can accept a bundle this cycle.
- in_alu_res1  input  DATA_W  alu1 result (memory address or data).
- in_alu_res2  input  DATA_W  alu2 result (EIP_next, updated ESP, string pointer).
- in_mem_rd_en, in_mem_wr_en  input  1 each  memory read/write request.
- in_mem_rd_size, in_mem_wr_size  input  2 each  00 byte, 01 word, 10 dword, 11 illegal.
- in_wb_reg_id  input  REG_ID_W  destination GPR.
- in_ld_reg, in_ld_esp  input  1 each  writeback enables for GPR / ESP (ESP takes alu_res2).
- out_valid  output  1  head bundle valid.
- out_ready  input  1  memory stage accepts head bundle.
- out_* (same fields as in_*)  output  as in_*  head bundle.
- stall_cnt  output  STALL_CNT_W  cycles with out_valid=1 and out_ready=0.
- size_err  output  1  sticky: an accepted bundle had an enabled access with size 11.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - out_valid=0, all out_* payload=0, stall_cnt=0, size_err=0, state EMPTY.
  - in_ready=1 from the first clock edge after deassertion.
- Storage is a main register (drives out_*) plus a skid register.
- States:
  - EMPTY: main and skid invalid.
  - ONE: main valid.
  - FULL: main and skid valid.
- in_ready is a registered signal, equal to (state != FULL). It has no combinational path from out_ready.
- A transfer in occurs when in_valid & in_ready; a transfer out occurs when out_valid & out_ready.
- EMPTY:
  - Transfer in loads main -> ONE.
- ONE:
  - In only: load skid -> FULL.
  - Out only: -> EMPTY.
  - In and out: load main with the new bundle, stay ONE.
  - Neither: hold.
- FULL (in_ready=0):
  - Out: skid moves to main -> ONE.
  - Otherwise hold.
- Latency is one cycle: a bundle accepted at edge N appears on out_* after edge N.
- Order is strict FIFO; the skid is always younger than main.
- out_* stays stable while out_valid=1 and out_ready=0 (payload hold rule).
- Flush:
  - Synchronous, with priority over every transfer in the same cycle.
  - Next state is EMPTY, out_valid=0 and in_ready=1.
  - A bundle offered on the flush cycle is discarded.
  - Payload registers need not clear.
  - stall_cnt and size_err are unaffected by flush.
- stall_cnt:
  - Increments on each cycle with out_valid=1, out_ready=0 and flush=0.
  - Saturates at all-ones and never wraps.
  - Cleared only by reset.
- size_err:
  - Set on a transfer in when (in_mem_rd_en & in_mem_rd_size==11) or (in_mem_wr_en & in_mem_wr_size==11).
  - Sizes with the enable low are ignored.
  - Once set, it holds until reset; the bundle itself is still passed through unchanged.
- Payload is passed bit-exact, with no arithmetic.
- Reset asserted mid-operation drops all bundles immediately.

Decomposition:
- Shared package (cpu_pkg):
  - mem_size_t enum with values BYTE=00, WORD=01, DWORD=10.
  - ex_mem_bundle_t packed struct holding all payload fields.
  - Constant MEM_SIZE_ILLEGAL=2'b11.
- Sub-module pipe_skid_reg: a generic bundle-width two-entry skid with valid/ready/flush, parameterised on the struct width.
- ex_mem_skid instantiates pipe_skid_reg and adds stall_cnt and size_err.

Test Plan:
- Streaming with out_ready=1:
  - Stimulus: 4 back-to-back bundles with alu_res2 = 0x100, 0x104, 0x108, 0x10C.
  - Required: out_valid high from cycle 1 to cycle 4, same order, in_ready constant 1.
- Stall fill:
  - Stimulus: out_ready=0, offer A (res1=0xAAAA0000) then B (0xBBBB0000).
  - Required: both accepted; in_ready=0 after B; C held off.
  - Release out_ready: A, B, C drain in order; stall_cnt equals the number of stalled cycles.
- Flush in FULL with in_valid=1:
  - Required next cycle: out_valid=0, in_ready=1.
  - The offered bundle never appears; a following bundle D appears alone.
- Illegal size:
  - Bundle with mem_wr_en=1, wr_size=11 -> size_err=1 permanently and the bundle is still delivered.
  - Bundle with mem_rd_en=0, rd_size=11 -> size_err stays 0.
- Saturation:
  - Use STALL_CNT_W=4 and hold a stall for 20 cycles -> stall_cnt=15, with no wrap.
- Async reset:
  - Pulse rst_n low between clock edges while FULL.
  - Required immediately: out_valid=0, stall_cnt=0, size_err=0.
  - in_ready=1 after the first edge following deassertion.
